fir_csa_scheduler: RTL
======================

// Module: fir_csa_scheduler
// PURPOSE
// Time-multiplexed FIR tap scheduler for the ECG denoising path. It owns the sample delay
// line and the coefficient bank, forms two tap products per cycle, and sequences one shared
// 32-bit three-operand carry-save adder (acc + p0 + p1) across all taps.
// Produces one filtered sample per accepted input, with valid/ready handshakes on both sides.
// PARAMETERS
// TAPS  16  number of filter taps; even, >=2; TAPS/2 adder passes per sample
// DW    16  signed input sample width
// CW    16  signed coefficient width; DW+CW <= 32
// PORTS
// clk         in   1                   rising-edge clock
// rst_n       in   1                   synchronous active-low reset
// in_valid    in   1                   input sample valid
// in_ready    out  1                   block can accept a sample
// in_data     in   DW                  signed ECG sample
// coef_we     in   1                   coefficient write strobe
// coef_addr   in   $clog2(TAPS)        coefficient index h[k]
// coef_wdata  in   CW                  signed coefficient
// busy        out  1                   1 in any state other than IDLE
// csa_a       out  32                  adder operand: accumulator
// csa_b       out  32                  adder operand: even-tap product
// csa_c       out  32                  adder operand: odd-tap product
// csa_sum     in   32                  adder result, same-cycle combinational return
// out_valid   out  1                   filtered result valid
// out_ready   in   1                   downstream accepts result
// out_data    out  32                  signed filtered result, two's complement
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE; x[0..TAPS-1]=0; h[0..TAPS-1]=0; acc=0; pair=0;
//   out_valid=0; out_data=0; busy=0; in_ready=1 from the first cycle after reset.
// - Reset mid-ACCUM/DONE aborts: partial sum and pending result are discarded.
// - FSM: IDLE -> ACCUM -> DONE -> IDLE.
// - in_ready = (state==IDLE). Accept = in_valid & in_ready.
//   On accept: x[k]<=x[k-1] for k>=1, x[0]<=in_data, acc<=0, pair<=0, state<=ACCUM.
// - ACCUM, pair p in 0..TAPS/2-1:
//   csa_a=acc, csa_b=sext32(h[2p]*x[2p]), csa_c=sext32(h[2p+1]*x[2p+1]).
//   Products are signed DW x CW, sign-extended to 32 bits.
//   acc<=csa_sum; p<=p+1; at p==TAPS/2-1: state<=DONE.
// - Outside ACCUM: csa_a/b/c = 0; csa_sum is ignored.
// - DONE: out_valid=1, out_data=acc, held stable until out_ready=1.
//   On out_valid&out_ready: out_valid<=0, state<=IDLE.
// - Latency: accept at edge t -> out_valid high after edge t+TAPS/2.
//   Earliest next accept is the cycle after the result handshake; throughput is 1 sample per TAPS/2+2 cycles.
// - Arithmetic: acc wraps modulo 2^32. No saturation and no overflow flag.
// - Coefficient write: honoured only in IDLE (h[coef_addr]<=coef_wdata); ignored when busy=1.
//   coef_we and accept on the same IDLE edge: both occur, and the new coefficient is used by that sample.
// - out_ready while out_valid=0 has no effect. in_valid while busy: sample is not taken; the sender must hold it.
// TESTING
// - Impulse, TAPS=16: h[k]=k+1; in 1 then fifteen 0s -> out_data = 1,2,...,16.
//   Each out_valid arrives 8 cycles after its accept.
// - Step with all h=1: in 100 x16 -> out_data = 100,200,...,1600, then steady 1600.
// - Signed/wrap: h all 0x7FFF, x all 0x7FFF -> out_data = 16*0x3FFF0001 mod 2^32 = 0xFFF00010.
//   h[0]=-1 with x=5 (others 0) -> 0xFFFFFFFB.
// - Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable,
//   in_ready=0 throughout; after out_ready=1, in_ready=1 on the next cycle.
// - Coefficient gating: coef_we during ACCUM -> h is unchanged and the result is unaffected.
//   coef_we with accept in IDLE -> the new coefficient is applied to that sample.
// - Reset in ACCUM pass 3 -> next cycle: out_valid=0, in_ready=1, csa_a/b/c=0.
//   Next impulse reproduces the impulse-test output with the delay line zeroed.

Source files
------------

// File: rtl/fir_csa_scheduler_if.sv
// Stream, coefficient and carry-save-adder signals of the FIR tap scheduler.
// The slave modport is the scheduler's view; master is the surrounding datapath/environment.
interface fir_csa_scheduler_if #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int AW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_wdata;
    logic [31:0]   csa_a;
    logic [31:0]   csa_b;
    logic [31:0]   csa_c;
    logic [31:0]   csa_sum;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_wdata, csa_sum, out_ready,
        input  in_ready, csa_a, csa_b, csa_c, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_wdata, csa_sum, out_ready,
        output in_ready, csa_a, csa_b, csa_c, out_valid, out_data
    );
endinterface

// File: rtl/fir_csa_scheduler.sv
// Time-multiplexed FIR: owns delay line and coefficients, feeds two tap products per
// cycle into one external 3-operand carry-save adder, one result per accepted sample.
module fir_csa_scheduler #(
    parameter int TAPS = 16,
    parameter int DW   = 16,
    parameter int CW   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    fir_csa_scheduler_if.slave    bus
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW = DW + CW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nx_s;
    logic signed [DW-1:0] x_r [TAPS];
    logic signed [CW-1:0] h_r [TAPS];
    logic [31:0]          acc_r;
    logic [31:0]          out_data_r;
    logic                 out_valid_r;
    // Holds the even tap index 2*pair, so the odd partner is just the LSB set.
    logic [AW-1:0]        tap_idx_r;
    logic [AW-1:0]        odd_idx_s;
    logic signed [PW-1:0] prod_even_s;
    logic signed [PW-1:0] prod_odd_s;
    logic [31:0]          csa_a_s;
    logic [31:0]          csa_b_s;
    logic [31:0]          csa_c_s;
    logic                 accept_s;
    logic                 last_pass_s;

    assign odd_idx_s   = tap_idx_r | AW'(1);
    assign prod_even_s = h_r[tap_idx_r] * x_r[tap_idx_r];
    assign prod_odd_s  = h_r[odd_idx_s] * x_r[odd_idx_s];
    assign accept_s    = bus.in_valid & (state_r == IDLE);
    assign last_pass_s = (tap_idx_r == AW'(TAPS - 2));

    assign bus.in_ready  = (state_r == IDLE);
    assign busy          = (state_r != IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.csa_a     = csa_a_s;
    assign bus.csa_b     = csa_b_s;
    assign bus.csa_c     = csa_c_s;

    // Next-state decode and adder operand steering.
    always_comb begin
        state_nx_s = state_r;
        csa_a_s    = 32'd0;
        csa_b_s    = 32'd0;
        csa_c_s    = 32'd0;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nx_s = ACCUM;
                else          state_nx_s = IDLE;
            end
            ACCUM: begin
                csa_a_s = acc_r;
                csa_b_s = 32'(prod_even_s);
                csa_c_s = 32'(prod_odd_s);
                if (last_pass_s) state_nx_s = DONE;
                else             state_nx_s = ACCUM;
            end
            DONE: begin
                if (bus.out_ready) state_nx_s = IDLE;
                else               state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nx_s;
    end

    // Delay line, coefficient bank, accumulator and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_r[k] <= '0;
                h_r[k] <= '0;
            end
            acc_r       <= 32'd0;
            tap_idx_r   <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.coef_we) h_r[bus.coef_addr] <= $signed(bus.coef_wdata);
                    if (accept_s) begin
                        for (int k = 1; k < TAPS; k++) x_r[k] <= x_r[k-1];
                        x_r[0]    <= $signed(bus.in_data);
                        acc_r     <= 32'd0;
                        tap_idx_r <= '0;
                    end
                end
                ACCUM: begin
                    acc_r     <= bus.csa_sum;
                    tap_idx_r <= tap_idx_r + AW'(2);
                    if (last_pass_s) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= bus.csa_sum;
                    end
                end
                DONE: begin
                    if (bus.out_ready) out_valid_r <= 1'b0;
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end
endmodule
